net_if_status_unit: RTL and testbench
=====================================

Name: net_if_status_unit

Overview:
- Network-interface endpoint on the CPU side of the neuromorphic fabric.
- Buffers outgoing spike packets that the CPU writes and presents them to the network over a valid/ready handshake.
- Buffers incoming packets, which the CPU reads out in order.
- Produces the 32-bit NETWORK_STATUS word that the register file mirrors into x29 every cycle, and raises an RX interrupt toward the ISR/PC-save logic.

Parameters:
- DEPTH, 8, entries per FIFO; power of 2, range 2..128.
- DATA_WIDTH, 32, packet width in bits.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- TX_WRITE  in  1  CPU push into the TX FIFO.
- TX_DATA  in  DATA_WIDTH  packet to push.
- NET_TX_VALID  out  1  TX head available to the network.
- NET_TX_DATA  out  DATA_WIDTH  TX FIFO head.
- NET_TX_READY  in  1  network accepts the TX head.
- NET_RX_VALID  in  1  network offers a packet.
- NET_RX_DATA  in  DATA_WIDTH  offered packet.
- NET_RX_READY  out  1  unit can accept an RX packet.
- RX_READ  in  1  CPU pop from the RX FIFO.
- RX_DATA  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
- STATUS_CLR  in  1  clears the sticky error bits.
- IRQ_EN  in  1  RX interrupt enable.
- IRQ_ACK  in  1  ISR entry acknowledge.
- IRQ  out  1  RX interrupt request.
- NETWORK_STATUS  out  32  registered status word.

Behaviour:
Reset:
- Reset is RESET, synchronous, active-high; clock is CLK.
- On reset: both FIFOs empty, pointers and counts 0, sticky bits 0, FSM in IDLE.
- Output reset values: NET_TX_VALID=0, NET_TX_DATA=0, RX_DATA=0, IRQ=0, NET_RX_READY=1.
- NETWORK_STATUS reset value = 0x000A0000 (tx_empty and rx_empty set).
- RESET mid-transfer discards all buffered packets; no handshake completes in the reset cycle.

FIFOs:
- Circular buffers with ptr width log2(DEPTH) and count width log2(DEPTH)+1.
- Pointers wrap from DEPTH-1 to 0.
- full and empty are evaluated on start-of-cycle state.

TX path:
- Push when TX_WRITE && !tx_full.
- Pop when NET_TX_VALID && NET_TX_READY.
- NET_TX_VALID = !tx_empty.
- NET_TX_DATA = head; it must hold stable while VALID && !READY.
- TX_WRITE while full: packet dropped, tx_ovf set. This applies even if a pop occurs in the same cycle.
- Push and pop in the same cycle while non-full and non-empty: count unchanged.

RX path:
- NET_RX_READY = !rx_full.
- Push when NET_RX_VALID && NET_RX_READY.
- Pop when RX_READ && !rx_empty.
- RX_READ while empty: ignored, rx_udf set.
- A full RX FIFO backpressures the network; no data is lost.

NETWORK_STATUS, registered, 1-cycle latency after the FIFO state update:
- [7:0] tx_count, zero-extended.
- [15:8] rx_count, zero-extended.
- [16] tx_full.
- [17] tx_empty.
- [18] rx_full.
- [19] rx_empty.
- [20] rx_udf, sticky.
- [21] tx_ovf, sticky.
- [22] IRQ.
- [31:23] 0.
- Sticky clear rule: STATUS_CLR clears the sticky bits. If a set event and STATUS_CLR occur in the same cycle, set wins.

IRQ FSM (states IDLE, PEND, SERVICE):
- IDLE -> PEND when IRQ_EN && !rx_empty.
- PEND: IRQ=1 (registered).
  - PEND -> SERVICE on IRQ_ACK.
  - PEND -> IDLE if IRQ_EN drops.
- SERVICE: IRQ=0; SERVICE -> IDLE when rx_empty.
- No re-trigger while in SERVICE.
- IRQ_ACK outside PEND is ignored.

Decomposition:
- Package net_if_pkg holds:
  - status bit-index constants;
  - FSM state typedef with 2-bit encoding (IDLE=0, PEND=1, SERVICE=2);
  - reset status constant 0x000A0000.
- One sub-module, net_sync_fifo (parameters DEPTH and DATA_WIDTH; outputs full, empty, count, head), instantiated twice for TX and RX.
- FSM and status register stay in the top module.

Test Plan:
- Write 0x11,0x22,0x33 with NET_TX_READY=0 -> NET_TX_VALID=1, NET_TX_DATA=0x11 held stable; status[7:0]=3. Then raise READY for 3 cycles -> 0x11,0x22,0x33 leave in order, then status=0x000A0000.
- Issue 9 TX_WRITEs (DEPTH=8) with READY=0 -> status[16]=1, [21]=1, count 8; the 9th packet never appears. Pulse STATUS_CLR -> [21]=0.
- Hold NET_RX_VALID=1 for 10 cycles -> NET_RX_READY drops after 8 accepts; status[18]=1; then 8 RX_READs return packets in order.
- Assert RX_READ while empty -> RX_DATA unchanged, status[20]=1.
- Set IRQ_EN=1, push 1 RX packet -> IRQ=1 (PEND). Pulse IRQ_ACK -> IRQ=0. Push a 2nd packet -> IRQ stays 0. Read 2 packets -> FSM returns to IDLE; a 3rd packet re-raises IRQ.
- Assert RESET with 4 packets in each FIFO and IRQ=1 -> next cycle all outputs at reset values and status=0x000A0000.

Source files
------------

// File: rtl/net_if_pkg.sv
// Shared constants for the network-interface status unit: status word layout,
// reset status value and IRQ FSM state encoding.
package net_if_pkg;

  localparam int unsigned STATUS_W      = 32;
  localparam int unsigned ST_CNT_W      = 8;

  localparam int unsigned ST_TX_CNT_LSB = 0;
  localparam int unsigned ST_RX_CNT_LSB = 8;
  localparam int unsigned ST_TX_FULL    = 16;
  localparam int unsigned ST_TX_EMPTY   = 17;
  localparam int unsigned ST_RX_FULL    = 18;
  localparam int unsigned ST_RX_EMPTY   = 19;
  localparam int unsigned ST_RX_UDF     = 20;
  localparam int unsigned ST_TX_OVF     = 21;
  localparam int unsigned ST_IRQ        = 22;

  // Both FIFOs empty, nothing else set.
  localparam logic [STATUS_W-1:0] STATUS_RST = 32'h000A_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/net_if_status_unit_if.sv
// CPU- and network-side signal bundle of the status unit; master drives the
// unit's inputs, slave is the unit itself.
interface net_if_status_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  TX_WRITE;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  NET_TX_VALID;
  logic [DATA_WIDTH-1:0] NET_TX_DATA;
  logic                  NET_TX_READY;
  logic                  NET_RX_VALID;
  logic [DATA_WIDTH-1:0] NET_RX_DATA;
  logic                  NET_RX_READY;
  logic                  RX_READ;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  STATUS_CLR;
  logic                  IRQ_EN;
  logic                  IRQ_ACK;
  logic                  IRQ;
  logic [31:0]           NETWORK_STATUS;

  modport master (
    output TX_WRITE, TX_DATA, NET_TX_READY, NET_RX_VALID, NET_RX_DATA,
           RX_READ, STATUS_CLR, IRQ_EN, IRQ_ACK,
    input  NET_TX_VALID, NET_TX_DATA, NET_RX_READY, RX_DATA, IRQ, NETWORK_STATUS
  );

  modport slave (
    input  TX_WRITE, TX_DATA, NET_TX_READY, NET_RX_VALID, NET_RX_DATA,
           RX_READ, STATUS_CLR, IRQ_EN, IRQ_ACK,
    output NET_TX_VALID, NET_TX_DATA, NET_RX_READY, RX_DATA, IRQ, NETWORK_STATUS
  );
endinterface

// File: rtl/net_sync_fifo.sv
// Single-clock circular FIFO with first-word fall-through head; head reads as
// zero while empty so a drained FIFO presents a clean bus.
module net_sync_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [DATA_WIDTH-1:0]       i_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic [DATA_WIDTH-1:0]       o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is not reset; emptiness alone defines valid contents.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/net_if_status_unit.sv
// CPU-side network endpoint: TX/RX packet FIFOs, registered NETWORK_STATUS
// snapshot with sticky error bits, and the RX interrupt FSM.
module net_if_status_unit
  import net_if_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  net_if_status_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [CNT_W-1:0]      w_tx_count, w_rx_count;
  logic [DATA_WIDTH-1:0] w_tx_head, w_rx_head;
  logic                  w_tx_pop, w_rx_push;
  logic                  w_tx_ovf_set, w_rx_udf_set;
  logic                  r_tx_ovf, r_rx_udf;
  irq_state_t            r_state, w_state_nxt;
  logic                  r_irq;
  logic [STATUS_W-1:0]   w_status, r_status;

  assign w_tx_pop  = !w_tx_empty && bus.NET_TX_READY;
  assign w_rx_push = bus.NET_RX_VALID && !w_rx_full;

  net_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_tx_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (bus.TX_WRITE),
    .i_pop   (w_tx_pop),
    .i_data  (bus.TX_DATA),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count),
    .o_head  (w_tx_head)
  );

  net_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_rx_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_rx_push),
    .i_pop   (bus.RX_READ),
    .i_data  (bus.NET_RX_DATA),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count),
    .o_head  (w_rx_head)
  );

  assign bus.NET_TX_VALID   = !w_tx_empty;
  assign bus.NET_TX_DATA    = w_tx_head;
  assign bus.NET_RX_READY   = !w_rx_full;
  assign bus.RX_DATA        = w_rx_head;
  assign bus.IRQ            = r_irq;
  assign bus.NETWORK_STATUS = r_status;

  // Sticky errors: a set event in the same cycle as STATUS_CLR wins.
  assign w_tx_ovf_set = bus.TX_WRITE && w_tx_full;
  assign w_rx_udf_set = bus.RX_READ && w_rx_empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      if (w_tx_ovf_set)        r_tx_ovf <= 1'b1;
      else if (bus.STATUS_CLR) r_tx_ovf <= 1'b0;
      if (w_rx_udf_set)        r_rx_udf <= 1'b1;
      else if (bus.STATUS_CLR) r_rx_udf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= (w_state_nxt == PEND);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.IRQ_EN && !w_rx_empty) w_state_nxt = PEND;
      PEND: begin
        if (bus.IRQ_ACK)      w_state_nxt = SERVICE;
        else if (!bus.IRQ_EN) w_state_nxt = IDLE;
      end
      SERVICE: if (w_rx_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status is a one-cycle-late snapshot of the unit's register state.
  always_comb begin
    w_status = '0;
    w_status[ST_TX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_tx_count);
    w_status[ST_RX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_rx_count);
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_UDF]   = r_rx_udf;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_IRQ]      = r_irq;
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_status <= STATUS_RST;
    else       r_status <= w_status;
  end

endmodule

// File: tb/tb_net_if_status_unit.sv
// Directed bench for net_if_status_unit: queue-based reference model checked
// every cycle, plus literal expectations from the test plan.
module tb_net_if_status_unit;

  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  net_if_status_unit_if #(.DATA_WIDTH(32)) bus ();

  net_if_status_unit #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet queues, sticky flags and interrupt mode.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_ovf, m_udf, m_irq, chk_en;
  int          m_mode;
  logic [31:0] m_status;
  int          txn, rxn;
  bit          txf, txe, rxf, rxe, ovf_set, udf_set;

  initial begin
    chk_en = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        txq.delete();
        rxq.delete();
        m_ovf = 0; m_udf = 0; m_irq = 0; m_mode = 0;
        m_status = 32'h000A_0000;
        chk_en = 1;
      end else begin
        txn = txq.size();  rxn = rxq.size();
        txf = (txn == DEPTH); txe = (txn == 0);
        rxf = (rxn == DEPTH); rxe = (rxn == 0);
        m_status = 32'(txn) | (32'(rxn) << 8) | (32'(txf) << 16) | (32'(txe) << 17)
                 | (32'(rxf) << 18) | (32'(rxe) << 19) | (32'(m_udf) << 20)
                 | (32'(m_ovf) << 21) | (32'(m_irq) << 22);
        ovf_set = bus.TX_WRITE && txf;
        udf_set = bus.RX_READ && rxe;
        if (!txe && bus.NET_TX_READY) void'(txq.pop_front());
        if (bus.TX_WRITE && !txf) txq.push_back(bus.TX_DATA);
        if (bus.RX_READ && !rxe) void'(rxq.pop_front());
        if (bus.NET_RX_VALID && !rxf) rxq.push_back(bus.NET_RX_DATA);
        m_ovf = ovf_set || (m_ovf && !bus.STATUS_CLR);
        m_udf = udf_set || (m_udf && !bus.STATUS_CLR);
        case (m_mode)
          0: if (bus.IRQ_EN && !rxe) m_mode = 1;
          1: if (bus.IRQ_ACK) m_mode = 2; else if (!bus.IRQ_EN) m_mode = 0;
          default: if (rxe) m_mode = 0;
        endcase
        m_irq = (m_mode == 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("tx_valid", 32'(bus.NET_TX_VALID), 32'(txq.size() != 0));
        chk("tx_data", bus.NET_TX_DATA, (txq.size() != 0) ? txq[0] : 32'h0);
        chk("rx_ready", 32'(bus.NET_RX_READY), 32'(rxq.size() != DEPTH));
        chk("rx_data", bus.RX_DATA, (rxq.size() != 0) ? rxq[0] : 32'h0);
        chk("irq", 32'(bus.IRQ), 32'(m_irq));
        chk("status", bus.NETWORK_STATUS, m_status);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] tx_exp [3];
  int          acc;

  initial begin
    rst = 1'b1;
    bus.TX_WRITE = 0; bus.TX_DATA = '0; bus.NET_TX_READY = 0;
    bus.NET_RX_VALID = 0; bus.NET_RX_DATA = '0; bus.RX_READ = 0;
    bus.STATUS_CLR = 0; bus.IRQ_EN = 0; bus.IRQ_ACK = 0;
    step(2);
    rst = 1'b0;
    chk("rst_status", bus.NETWORK_STATUS, 32'h000A_0000);
    chk("rst_rx_ready", 32'(bus.NET_RX_READY), 32'd1);

    // TX: three packets held behind a stalled network, then drained in order.
    tx_exp[0] = 32'h11; tx_exp[1] = 32'h22; tx_exp[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      bus.TX_WRITE = 1; bus.TX_DATA = tx_exp[i];
      step();
      chk("tx_head_hold", bus.NET_TX_DATA, 32'h11);
    end
    bus.TX_WRITE = 0;
    step();
    chk("tx_cnt3", {24'h0, bus.NETWORK_STATUS[7:0]}, 32'd3);
    chk("tx_valid3", 32'(bus.NET_TX_VALID), 32'd1);
    bus.NET_TX_READY = 1;
    for (int i = 0; i < 3; i++) begin
      chk("tx_order", bus.NET_TX_DATA, tx_exp[i]);
      step();
    end
    bus.NET_TX_READY = 0;
    step();
    chk("tx_drained_status", bus.NETWORK_STATUS, 32'h000A_0000);

    // TX overflow: ninth write dropped, sticky flag cleared by STATUS_CLR.
    for (int i = 0; i < 9; i++) begin
      bus.TX_WRITE = 1; bus.TX_DATA = 32'h100 + 32'(i);
      step();
    end
    bus.TX_WRITE = 0;
    step();
    chk("tx_full_bit", 32'(bus.NETWORK_STATUS[16]), 32'd1);
    chk("tx_ovf_bit", 32'(bus.NETWORK_STATUS[21]), 32'd1);
    chk("tx_cnt8", {24'h0, bus.NETWORK_STATUS[7:0]}, 32'd8);
    bus.STATUS_CLR = 1;
    step();
    bus.STATUS_CLR = 0;
    step();
    chk("tx_ovf_clr", 32'(bus.NETWORK_STATUS[21]), 32'd0);
    bus.NET_TX_READY = 1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_ovf_order", bus.NET_TX_DATA, 32'h100 + 32'(i));
      step();
    end
    chk("tx_no_ninth", 32'(bus.NET_TX_VALID), 32'd0);
    bus.NET_TX_READY = 0;
    step();

    // RX backpressure: ten offers, eight accepted, then read back in order.
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.NET_RX_VALID = 1; bus.NET_RX_DATA = 32'h200 + 32'(i);
      if (bus.NET_RX_READY) acc++;
      step();
    end
    bus.NET_RX_VALID = 0;
    chk("rx_accepts", 32'(acc), 32'd8);
    chk("rx_ready_low", 32'(bus.NET_RX_READY), 32'd0);
    step();
    chk("rx_full_bit", 32'(bus.NETWORK_STATUS[18]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("rx_order", bus.RX_DATA, 32'h200 + 32'(i));
      bus.RX_READ = 1;
      step();
    end
    bus.RX_READ = 0;

    // RX underflow on an empty FIFO.
    bus.RX_READ = 1;
    step();
    bus.RX_READ = 0;
    chk("rx_udf_data", bus.RX_DATA, 32'h0);
    step();
    chk("rx_udf_bit", 32'(bus.NETWORK_STATUS[20]), 32'd1);
    bus.STATUS_CLR = 1;
    step();
    bus.STATUS_CLR = 0;
    step();
    chk("rx_udf_clr", 32'(bus.NETWORK_STATUS[20]), 32'd0);

    // Interrupt: raise, acknowledge, no re-trigger in service, re-raise after drain.
    bus.IRQ_EN = 1; bus.NET_RX_VALID = 1; bus.NET_RX_DATA = 32'h301;
    step();
    bus.NET_RX_VALID = 0;
    step();
    chk("irq_pend", 32'(bus.IRQ), 32'd1);
    bus.IRQ_ACK = 1;
    step();
    bus.IRQ_ACK = 0;
    chk("irq_ack", 32'(bus.IRQ), 32'd0);
    bus.NET_RX_VALID = 1; bus.NET_RX_DATA = 32'h302;
    step();
    bus.NET_RX_VALID = 0;
    step(2);
    chk("irq_no_retrig", 32'(bus.IRQ), 32'd0);
    chk("irq_rx_head", bus.RX_DATA, 32'h301);
    bus.RX_READ = 1;
    step(2);
    bus.RX_READ = 0;
    step();
    bus.NET_RX_VALID = 1; bus.NET_RX_DATA = 32'h303;
    step();
    bus.NET_RX_VALID = 0;
    step();
    chk("irq_reraise", 32'(bus.IRQ), 32'd1);

    // Reset with four packets in each FIFO and IRQ pending; handshakes held active.
    for (int i = 0; i < 4; i++) begin
      bus.TX_WRITE = 1; bus.TX_DATA = 32'h401 + 32'(i);
      bus.NET_RX_VALID = (i < 3); bus.NET_RX_DATA = 32'h502 + 32'(i);
      step();
    end
    bus.TX_WRITE = 0; bus.NET_RX_VALID = 0;
    step();
    chk("pre_rst_tx_cnt", {24'h0, bus.NETWORK_STATUS[7:0]}, 32'd4);
    chk("pre_rst_rx_cnt", {24'h0, bus.NETWORK_STATUS[15:8]}, 32'd4);
    chk("pre_rst_irq", 32'(bus.IRQ), 32'd1);
    rst = 1;
    bus.TX_WRITE = 1; bus.NET_TX_READY = 1; bus.NET_RX_VALID = 1; bus.RX_READ = 1;
    step();
    rst = 0;
    bus.TX_WRITE = 0; bus.NET_TX_READY = 0; bus.NET_RX_VALID = 0; bus.RX_READ = 0;
    chk("rst2_tx_valid", 32'(bus.NET_TX_VALID), 32'd0);
    chk("rst2_tx_data", bus.NET_TX_DATA, 32'h0);
    chk("rst2_rx_data", bus.RX_DATA, 32'h0);
    chk("rst2_irq", 32'(bus.IRQ), 32'd0);
    chk("rst2_rx_ready", 32'(bus.NET_RX_READY), 32'd1);
    chk("rst2_status", bus.NETWORK_STATUS, 32'h000A_0000);
    step(2);
    chk("post_rst_status", bus.NETWORK_STATUS, 32'h000A_0000);

    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
